// File: rtl/ysyx_22050550_axi_dev_resp_if.sv
// AXI4 device-port bundle between the LSU device master and the register-array responder.
interface ysyx_22050550_axi_dev_resp_if;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;

  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;

  logic        aw_valid;
  logic        aw_ready;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;

  logic        w_valid;
  logic        w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;

  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_resp;

  modport master (
    output ar_valid, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last,
    output r_ready,
    output aw_valid, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last,
    input  r_ready,
    input  aw_valid, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready
  );
endinterface

// File: rtl/ysyx_22050550_axi_dev_resp.sv
// Single-beat AXI4 responder backed by a 2^DEPTH_LOG2 x 64-bit register array,
// with programmable read latency and optional B channel.
module ysyx_22050550_axi_dev_resp #(
  parameter logic [63:0] ADDR_BASE  = 64'ha000_0000,
  parameter int          DEPTH_LOG2 = 6,
  parameter int          RD_LAT     = 2,
  parameter bit          BRESP_EN   = 1'b0
) (
  input logic                          clock,
  input logic                          reset,
  ysyx_22050550_axi_dev_resp_if.slave  axi
);
  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam int          IDX_W     = DEPTH_LOG2;
  localparam logic [63:0] ADDR_SPAN = 64'(DEPTH) << 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  function automatic logic in_range(input logic [63:0] addr);
    return (addr >= ADDR_BASE) && ((addr - ADDR_BASE) < ADDR_SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] index_of(input logic [63:0] addr);
    return IDX_W'((addr - ADDR_BASE) >> 3);
  endfunction

  function automatic logic [1:0] resp_of(input logic hit, input logic len_zero);
    if (!hit)      return RESP_DECERR;
    if (!len_zero) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  logic [63:0] mem [DEPTH];

  // ---------------------------------------------------------------- read side
  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic             r_hit;
  logic             r_len_zero;
  logic [IDX_W-1:0] r_idx;
  logic [63:0]      r_data_q;
  logic [1:0]       r_resp_q;

  logic             cap_hit;
  logic             cap_len_zero;
  logic [IDX_W-1:0] cap_idx;
  logic [63:0]      cap_data;
  logic [1:0]       cap_resp;

  // With RD_LAT==1 the capture edge is the AR handshake edge, so the
  // request fields come straight from the bus instead of the latches.
  always_comb begin
    cap_hit      = r_hit;
    cap_len_zero = r_len_zero;
    cap_idx      = r_idx;
    if (r_state == R_IDLE) begin
      cap_hit      = in_range(axi.ar_addr);
      cap_len_zero = (axi.ar_len == 8'd0);
      cap_idx      = index_of(axi.ar_addr);
    end
    cap_data = (cap_hit && cap_len_zero) ? mem[cap_idx] : 64'd0;
    cap_resp = resp_of(cap_hit, cap_len_zero);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= R_IDLE;
      r_cnt      <= 4'd0;
      r_hit      <= 1'b0;
      r_len_zero <= 1'b0;
      r_idx      <= '0;
      r_data_q   <= 64'd0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (axi.ar_valid) begin
            r_hit      <= in_range(axi.ar_addr);
            r_len_zero <= (axi.ar_len == 8'd0);
            r_idx      <= index_of(axi.ar_addr);
            if (RD_LAT == 1) begin
              r_state  <= R_DATA;
              r_data_q <= cap_data;
              r_resp_q <= cap_resp;
            end else begin
              r_state <= R_WAIT;
              r_cnt   <= 4'(RD_LAT - 1);
            end
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state  <= R_DATA;
            r_data_q <= cap_data;
            r_resp_q <= cap_resp;
          end
        end
        R_DATA: begin
          if (axi.r_ready) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign axi.ar_ready = (r_state == R_IDLE);
  assign axi.r_valid  = (r_state == R_DATA);
  assign axi.r_last   = (r_state == R_DATA);
  assign axi.r_data   = r_data_q;
  assign axi.r_resp   = r_resp_q;

  // --------------------------------------------------------------- write side
  logic [1:0]       w_state;
  logic             w_hit;
  logic             w_len_zero;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       b_resp_q;

  // The array lives in this block: a write lands on the W handshake edge,
  // after any read capture on that same edge has already sampled it.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state    <= W_IDLE;
      w_hit      <= 1'b0;
      w_len_zero <= 1'b0;
      w_idx      <= '0;
      b_resp_q   <= RESP_OKAY;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'd0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (axi.aw_valid) begin
            w_hit      <= in_range(axi.aw_addr);
            w_len_zero <= (axi.aw_len == 8'd0);
            w_idx      <= index_of(axi.aw_addr);
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (axi.w_valid) begin
            if (w_hit && w_len_zero) begin
              for (int b = 0; b < 8; b++)
                if (axi.w_strb[b]) mem[w_idx][b*8 +: 8] <= axi.w_data[b*8 +: 8];
            end
            b_resp_q <= resp_of(w_hit, w_len_zero);
            w_state  <= BRESP_EN ? W_RESP : W_IDLE;
          end
        end
        W_RESP: begin
          if (axi.b_ready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign axi.aw_ready = (w_state == W_IDLE);
  assign axi.w_ready  = (w_state == W_DATA);
  assign axi.b_valid  = BRESP_EN && (w_state == W_RESP);
  assign axi.b_resp   = b_resp_q;

  // Size/burst/last are accepted but carry no meaning for single-beat access.
  logic unused_ok;
  assign unused_ok = ^{axi.ar_size, axi.ar_burst, axi.aw_size, axi.aw_burst, axi.w_last};
endmodule

// File: tb/tb_ysyx_22050550_axi_dev_resp.sv
// Bench for the device responder: two instances (RD_LAT=2/no B, RD_LAT=1/with B)
// driven one at a time, checked each cycle against a transaction-level model.
module tb_ysyx_22050550_axi_dev_resp;
  localparam logic [63:0] BASE  = 64'ha000_0000;
  localparam int          DEPTH = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bit          sel = 1'b0;
  logic        ar_valid = 1'b0, r_ready = 1'b1, aw_valid = 1'b0, w_valid = 1'b0, b_ready = 1'b1;
  logic [63:0] ar_addr = '0, aw_addr = '0, w_data = '0;
  logic [7:0]  ar_len = '0, aw_len = '0, w_strb = '0;

  ysyx_22050550_axi_dev_resp_if ifa ();
  ysyx_22050550_axi_dev_resp_if ifb ();

  ysyx_22050550_axi_dev_resp #(.ADDR_BASE(BASE), .DEPTH_LOG2(6), .RD_LAT(2), .BRESP_EN(1'b0))
    dut_a (.clock(clock), .reset(reset), .axi(ifa));
  ysyx_22050550_axi_dev_resp #(.ADDR_BASE(BASE), .DEPTH_LOG2(6), .RD_LAT(1), .BRESP_EN(1'b1))
    dut_b (.clock(clock), .reset(reset), .axi(ifb));

  assign ifa.ar_valid = ar_valid & ~sel;  assign ifb.ar_valid = ar_valid & sel;
  assign ifa.aw_valid = aw_valid & ~sel;  assign ifb.aw_valid = aw_valid & sel;
  assign ifa.w_valid  = w_valid & ~sel;   assign ifb.w_valid  = w_valid & sel;
  assign ifa.ar_addr = ar_addr;  assign ifb.ar_addr = ar_addr;
  assign ifa.ar_len  = ar_len;   assign ifb.ar_len  = ar_len;
  assign ifa.aw_addr = aw_addr;  assign ifb.aw_addr = aw_addr;
  assign ifa.aw_len  = aw_len;   assign ifb.aw_len  = aw_len;
  assign ifa.w_data  = w_data;   assign ifb.w_data  = w_data;
  assign ifa.w_strb  = w_strb;   assign ifb.w_strb  = w_strb;
  assign ifa.r_ready = r_ready;  assign ifb.r_ready = r_ready;
  assign ifa.b_ready = b_ready;  assign ifb.b_ready = b_ready;
  assign ifa.ar_size = 3'd3;     assign ifb.ar_size = 3'd3;
  assign ifa.aw_size = 3'd3;     assign ifb.aw_size = 3'd3;
  assign ifa.ar_burst = 2'b01;   assign ifb.ar_burst = 2'b01;
  assign ifa.aw_burst = 2'b01;   assign ifb.aw_burst = 2'b01;
  assign ifa.w_last  = 1'b1;     assign ifb.w_last  = 1'b1;

  logic        obs_ar_ready, obs_r_valid, obs_r_last, obs_aw_ready, obs_w_ready, obs_b_valid;
  logic [63:0] obs_r_data;
  logic [1:0]  obs_r_resp, obs_b_resp;
  assign obs_ar_ready = sel ? ifb.ar_ready : ifa.ar_ready;
  assign obs_r_valid  = sel ? ifb.r_valid  : ifa.r_valid;
  assign obs_r_last   = sel ? ifb.r_last   : ifa.r_last;
  assign obs_r_data   = sel ? ifb.r_data   : ifa.r_data;
  assign obs_r_resp   = sel ? ifb.r_resp   : ifa.r_resp;
  assign obs_aw_ready = sel ? ifb.aw_ready : ifa.aw_ready;
  assign obs_w_ready  = sel ? ifb.w_ready  : ifa.w_ready;
  assign obs_b_valid  = sel ? ifb.b_valid  : ifa.b_valid;
  assign obs_b_resp   = sel ? ifb.b_resp   : ifa.b_resp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------ model
  function automatic bit m_hit(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'd8 * DEPTH);
  endfunction
  function automatic logic [1:0] m_resp(input logic [63:0] a, input logic [7:0] len);
    if (!m_hit(a)) return 2'b11;
    if (len != 8'd0) return 2'b10;
    return 2'b00;
  endfunction
  function automatic int m_idx(input logic [63:0] a);
    return int'((a - BASE) >> 3) % DEPTH;
  endfunction

  logic [63:0] mmem [DEPTH];
  bit          m_rpend;
  int          m_rdue;
  logic [63:0] m_raddr, m_rdata, m_waddr;
  logic [7:0]  m_rlen, m_wlen;
  logic [1:0]  m_rresp, m_bresp;
  bit          m_aw_open, m_w_open, m_b_owed;

  initial begin : model
    int   lat_m;
    bit   do_w;
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    forever begin
      @(posedge clock);
      lat_m = sel ? 1 : 2;
      do_w = 1'b0;
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        m_rpend = 1'b0; m_w_open = 1'b0; m_b_owed = 1'b0;
      end else begin
        // A read is outstanding from AR acceptance until its R beat is taken.
        if (m_rpend && cyc >= m_rdue) begin
          if (r_ready) m_rpend = 1'b0;
        end else if (!m_rpend && ar_valid) begin
          m_rpend = 1'b1; m_rdue = cyc + lat_m; m_raddr = ar_addr; m_rlen = ar_len;
        end
        // Data is sampled on the edge before it appears, ahead of any write on that edge.
        if (m_rpend && m_rdue == cyc + 1) begin
          m_rresp = m_resp(m_raddr, m_rlen);
          m_rdata = (m_rresp == 2'b00) ? mmem[m_idx(m_raddr)] : 64'd0;
        end
        if (m_b_owed) begin
          if (b_ready) m_b_owed = 1'b0;
        end else if (m_w_open) begin
          if (w_valid) begin
            m_bresp = m_resp(m_waddr, m_wlen);
            do_w = (m_bresp == 2'b00);
            m_w_open = 1'b0;
            m_b_owed = sel;
          end
        end else if (aw_valid) begin
          m_w_open = 1'b1; m_waddr = aw_addr; m_wlen = aw_len;
        end
        if (do_w)
          for (int b = 0; b < 8; b++)
            if (w_strb[b]) mmem[m_idx(m_waddr)][b*8 +: 8] = w_data[b*8 +: 8];
      end
      cyc++;
    end
  end

  initial begin : compare
    bit e_rv;
    forever begin
      @(negedge clock);
      if (!reset) begin
        e_rv = m_rpend && (cyc >= m_rdue);
        chk("ar_ready", obs_ar_ready, !m_rpend);
        chk("r_valid", obs_r_valid, e_rv);
        chk("r_last", obs_r_last, e_rv);
        chk("aw_ready", obs_aw_ready, !m_w_open && !m_b_owed);
        chk("w_ready", obs_w_ready, m_w_open);
        chk("b_valid", obs_b_valid, m_b_owed);
        if (e_rv) begin
          chk("r_data", obs_r_data, m_rdata);
          chk("r_resp", obs_r_resp, m_rresp);
        end
        if (m_b_owed) chk("b_resp", obs_b_resp, m_bresp);
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  function automatic bit sig_of(input int which);
    case (which)
      0: return obs_ar_ready;
      1: return obs_aw_ready;
      2: return obs_w_ready;
      3: return obs_r_valid;
      default: return obs_b_valid;
    endcase
  endfunction

  // Returns at the falling edge of the cycle in which the signal is seen high.
  task automatic wait_hs(input int which, input string nm);
    bit hs = 1'b0;
    int n = 0;
    while (!hs && n < 64) begin
      @(negedge clock);
      hs = sig_of(which);
      hs_cyc = cyc;
      if (!hs) begin @(posedge clock); #1; end
      n++;
    end
    chk({nm, "_seen"}, hs, 1'b1);
  endtask

  task automatic rd(input logic [63:0] a, input logic [7:0] len, input int hold,
                    output logic [63:0] d, output logic [1:0] rs, output int lat);
    int t0;
    ar_addr = a; ar_len = len; ar_valid = 1'b1; r_ready = (hold == 0);
    wait_hs(0, "ar_ready");
    t0 = hs_cyc;
    @(posedge clock); #1;
    ar_valid = 1'b0;
    wait_hs(3, "r_valid");
    lat = hs_cyc - t0;
    d = obs_r_data; rs = obs_r_resp;
    repeat (hold) begin @(posedge clock); #1; end
    r_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [63:0] a, input logic [7:0] len, input logic [63:0] data,
                    input logic [7:0] strb, input int bhold, output logic [1:0] br);
    br = 2'bxx;
    aw_addr = a; aw_len = len; aw_valid = 1'b1;
    wait_hs(1, "aw_ready");
    @(posedge clock); #1;
    aw_valid = 1'b0; w_data = data; w_strb = strb; w_valid = 1'b1;
    wait_hs(2, "w_ready");
    @(posedge clock); #1;
    w_valid = 1'b0;
    if (sel) begin
      b_ready = (bhold == 0);
      wait_hs(4, "b_valid");
      br = obs_b_resp;
      repeat (bhold) begin @(posedge clock); #1; end
      b_ready = 1'b1;
      @(posedge clock); #1;
    end
  endtask

  task automatic reset_checks();
    @(negedge clock);
    chk("rst ar_ready", obs_ar_ready, 1'b1);
    chk("rst aw_ready", obs_aw_ready, 1'b1);
    chk("rst r_valid", obs_r_valid, 1'b0);
    chk("rst r_data", obs_r_data, 64'd0);
    chk("rst r_resp", obs_r_resp, 2'b00);
    chk("rst r_last", obs_r_last, 1'b0);
    chk("rst w_ready", obs_w_ready, 1'b0);
    chk("rst b_valid", obs_b_valid, 1'b0);
    chk("rst b_resp", obs_b_resp, 2'b00);
    @(posedge clock); #1;
  endtask

  initial begin : stim
    logic [63:0] d;
    logic [1:0]  rs, br;
    int          lat;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    reset_checks();

    // Instance A: RD_LAT=2, no B channel.
    wr(64'ha000_0008, 8'd0, 64'h1122_3344_5566_7788, 8'hFF, 0, br);
    rd(64'ha000_0008, 8'd0, 0, d, rs, lat);
    chk("a full word", d, 64'h1122_3344_5566_7788);
    chk("a full resp", rs, 2'b00);
    chk("a latency", lat, 2);

    wr(64'ha000_0008, 8'd0, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 0, br);
    rd(64'ha000_0008, 8'd0, 0, d, rs, lat);
    chk("a strobe merge", d, 64'h1122_3344_BBBB_BBBB);

    rd(64'h9000_0000, 8'd0, 0, d, rs, lat);
    chk("a decerr data", d, 64'd0);
    chk("a decerr resp", rs, 2'b11);

    rd(64'ha000_0008, 8'd3, 0, d, rs, lat);
    chk("a burst resp", rs, 2'b10);
    chk("a burst data", d, 64'd0);

    // Burst and out-of-range writes must leave the array untouched.
    wr(64'ha000_0008, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, br);
    wr(64'ha000_0200, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, br);
    rd(64'ha000_000F, 8'd0, 0, d, rs, lat);
    chk("a unaligned/no-write", d, 64'h1122_3344_BBBB_BBBB);

    wr(64'ha000_01F8, 8'd0, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0, br);
    rd(64'ha000_01F8, 8'd0, 0, d, rs, lat);
    chk("a last word", d, 64'hDEAD_BEEF_CAFE_F00D);
    rd(64'ha000_0200, 8'd0, 0, d, rs, lat);
    chk("a one past end", rs, 2'b11);
    rd(64'ha000_0000, 8'd0, 0, d, rs, lat);
    chk("a word0 untouched", d, 64'd0);

    // Backpressure on R: stability is checked every cycle against the model.
    rd(64'ha000_0008, 8'd0, 5, d, rs, lat);
    chk("a held read", d, 64'h1122_3344_BBBB_BBBB);

    // Instance B: RD_LAT=1, with B channel.
    #0 reset = 1'b1; sel = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    reset_checks();

    wr(64'ha000_0010, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, br);
    chk("b bresp ok", br, 2'b00);

    // AR and AW together; the read captures before the W lands.
    ar_addr = 64'ha000_0010; ar_len = 8'd0; ar_valid = 1'b1;
    aw_addr = 64'ha000_0010; aw_len = 8'd0; aw_valid = 1'b1;
    r_ready = 1'b1; b_ready = 1'b1;
    @(posedge clock); #1;
    ar_valid = 1'b0; aw_valid = 1'b0;
    w_data = 64'hFFFF_0000_FFFF_0000; w_strb = 8'hFF; w_valid = 1'b1;
    @(negedge clock);
    chk("b same-edge r_valid", obs_r_valid, 1'b1);
    chk("b same-edge old data", obs_r_data, 64'h0123_4567_89AB_CDEF);
    @(posedge clock); #1;
    w_valid = 1'b0;
    @(posedge clock); #1;
    rd(64'ha000_0010, 8'd0, 0, d, rs, lat);
    chk("b new data", d, 64'hFFFF_0000_FFFF_0000);
    chk("b latency", lat, 1);

    wr(64'ha000_0018, 8'd0, 64'h5555_6666_7777_8888, 8'hF0, 3, br);
    chk("b held bresp", br, 2'b00);
    rd(64'ha000_0018, 8'd0, 0, d, rs, lat);
    chk("b upper strobe", d, 64'h5555_6666_0000_0000);
    wr(64'h0000_0000, 8'd0, 64'h1, 8'hFF, 0, br);
    chk("b bresp decerr", br, 2'b11);
    wr(64'ha000_0018, 8'd2, 64'h1, 8'hFF, 0, br);
    chk("b bresp slverr", br, 2'b10);

    // Reset while waiting for W data drops the write.
    aw_addr = 64'ha000_0020; aw_len = 8'd0; aw_valid = 1'b1;
    wait_hs(1, "aw_ready");
    @(posedge clock); #1;
    aw_valid = 1'b0; reset = 1'b1;
    w_data = 64'h1234; w_strb = 8'hFF; w_valid = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; w_valid = 1'b0;
    @(negedge clock);
    chk("b post-rst aw_ready", obs_aw_ready, 1'b1);
    chk("b post-rst w_ready", obs_w_ready, 1'b0);
    @(posedge clock); #1;
    rd(64'ha000_0020, 8'd0, 0, d, rs, lat);
    chk("b dropped write", d, 64'd0);

    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
